// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier sequencer.
//   state_t  : sequencer states (IDLE, RUN, DONE)
//   digit_t  : 3-bit signed Booth digit select (ZERO, POS1, POS2, NEG1, NEG2)
//   DEF_WIDTH: default operand width
package booth_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Encoding is the two's-complement value of the digit.
    typedef enum logic [2:0] {
        ZERO = 3'b000,
        POS1 = 3'b001,
        POS2 = 3'b010,
        NEG2 = 3'b110,
        NEG1 = 3'b111
    } digit_t;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Handshake/data bundle between the control unit and booth_mul_seq.
//   start      : request pulse (control unit -> multiplier)
//   a_in, b_in : signed operands, captured on accepted start
//   busy       : high while iterating
//   done       : one-cycle pulse, product valid
//   hi_out     : upper half of the product
//   lo_out     : lower half of the product
// Modports: master = control unit side, slave = multiplier side.
interface booth_mul_seq_if #(
    parameter int WIDTH = booth_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder and partial-product generator (combinational).
//   trip : {b[2c+1], b[2c], b[2c-1]} multiplier triplet
//   a    : latched multiplicand (signed)
//   pp   : digit * a as a 2*WIDTH-bit two's-complement value (unshifted)
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]         trip,
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] pp
);

    digit_t             dig;
    logic [2*WIDTH-1:0] a_ext;

    always_comb begin
        dig = ZERO;
        case (trip)
            3'b000, 3'b111: dig = ZERO;
            3'b001, 3'b010: dig = POS1;
            3'b011:         dig = POS2;
            3'b100:         dig = NEG2;
            default:        dig = NEG1;
        endcase
    end

    // Widen before negating/doubling so the most-negative a stays exact.
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

    always_comb begin
        pp = '0;
        case (dig)
            POS1:    pp = a_ext;
            POS2:    pp = a_ext << 1;
            NEG1:    pp = -a_ext;
            NEG2:    pp = -(a_ext << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle radix-4 Booth multiplier sequencer (one Booth digit per clock).
//   clk : rising-edge clock
//   clr : synchronous active-high reset, highest priority
//   bus : booth_mul_seq_if.slave (start, a_in, b_in, busy, done, hi_out, lo_out)
// Optional: define BOOTH_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all equal (remaining digits zero). Product is identical.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            clr,
    booth_mul_seq_if.slave  bus
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q;
    // Multiplier with the implicit b[-1]=0 appended; shifted right by two
    // (sign filled) each iteration so the current triplet is always [2:0].
    logic [WIDTH:0]     b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_sum;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               last;
    logic               accept;

    booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
        .trip (b_sh[2:0]),
        .a    (a_q),
        .pp   (pp)
    );

    assign acc_sum = acc + (pp << {count, 1'b0});

`ifdef BOOTH_EARLY_TERM_EN
    // b_sh[WIDTH:2] holds the not-yet-consumed bits (plus sign fill).
    assign last = (count == CW'(ITER - 1)) || (&b_sh[WIDTH:2]) || ~(|b_sh[WIDTH:2]);
`else
    assign last = (count == CW'(ITER - 1));
`endif

    assign accept = bus.start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            a_q   <= '0;
            b_sh  <= '0;
            acc   <= '0;
            count <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= bus.a_in;
                b_sh  <= {bus.b_in, 1'b0};
                acc   <= '0;
                count <= '0;
            end else if (state == RUN) begin
                acc   <= acc_sum;
                b_sh  <= {{2{b_sh[WIDTH]}}, b_sh[WIDTH:2]};
                count <= count + 1'b1;
                if (last) begin
                    hi_q <= acc_sum[2*WIDTH-1:WIDTH];
                    lo_q <= acc_sum[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Multi-cycle radix-4 Booth multiplier sequencer for the CPU's MUL instruction.
- Captures two signed operands on a start pulse and steps through WIDTH/2 Booth digits, one per clock.
- Accumulates the 2*WIDTH-bit product and presents HI/LO with a start/busy/done handshake to the control unit.
- Owns iteration counting, operand holding and result registering, so the control unit only issues start and waits for done.

Parameters:
- WIDTH, 32, operand width; must be even; product is 2*WIDTH bits.
- ITER, WIDTH/2, derived (localparam) Booth iteration count.

Ports:
- clk  input  1  system clock, rising-edge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a_in  input  WIDTH  signed multiplicand, captured on accepted start.
- b_in  input  WIDTH  signed multiplier, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE; product valid.
- hi_out  output  WIDTH  upper half of product; held until the next accepted start.
- lo_out  output  WIDTH  lower half of product; held likewise.

Behaviour:
- One clock domain (clk). clr is synchronous and active-high, with priority over all else.
- On clr: state=IDLE, busy=0, done=0, hi_out=0, lo_out=0, accumulator=0, count=0.
- States:
  - IDLE: wait. start=1 -> latch a,b; acc=0; count=0; prev bit p=0; go RUN.
  - RUN: busy=1. Each cycle:
    - Form triplet {b[2c+1], b[2c], p}, where c=count and p=b[2c-1] (or 0 when c=0).
    - Recode to digit in {-2,-1,0,+1,+2}: 000/111->0, 001/010->+1, 011->+2, 100->-2, 101/110->-1.
    - acc += sign_extend_2W(digit*a) << 2c. All arithmetic is 2*WIDTH two's complement; overflow beyond 2*WIDTH is discarded.
    - When count==ITER-1, register hi_out/lo_out from the final acc and go DONE; else count++.
  - DONE: done=1 for exactly one cycle, busy=0. start=1 here is accepted as in IDLE (back-to-back op, done not extended); otherwise go IDLE.
- Latency: start accepted on edge N -> done high in cycle N+ITER+1 (17 for WIDTH=32). Throughput: one op per ITER+1 cycles.
- start while in RUN is ignored; latched operands are unaffected by a_in/b_in changes after capture.
- hi_out/lo_out change only on entry to DONE or on clr; never show partial sums.
- clr mid-RUN aborts: no done pulse, outputs zeroed.
- a = most-negative value handled correctly: the 2*WIDTH sign extension precedes negation/doubling.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined: at the end of each RUN iteration, if the not-yet-consumed multiplier bits b[WIDTH-1 : 2c+1] are all equal (all 0 or all 1), the remaining digits are zero. In that case register the result and go DONE immediately. Latency becomes data-dependent, minimum 2 cycles to done.
- Undefined: fixed ITER iterations. Product is identical in both builds.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Booth digit encoding type (3-bit signed select: ZERO, POS1, POS2, NEG1, NEG2).
  - Default WIDTH constant.
- Sub-module booth_r4_recode: combinational; 3-bit triplet -> digit select, plus a partial-product generator producing a 2*WIDTH-bit signed partial product from the latched a.

Test Plan:
- clr, then start with a=6, b=7 -> busy cycles 1-16, done pulse cycle 17, hi=0x00000000, lo=0x0000002A; with BOOTH_EARLY_TERM_EN done in cycle 3.
- a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; a=0x7FFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFF, lo=0x80000001.
- Pulse start again at cycle 5 with a=9, b=9 during an op of 6*7 -> ignored, result still 42, done still at cycle 17.
- Start asserted in the DONE cycle with a=2, b=-4 -> new op accepted, next done 17 cycles later, hi=0xFFFFFFFF, lo=0xFFFFFFF8; previous result 42 held in between.
- clr at cycle 8 of an op -> next cycle busy=0, done=0, hi=lo=0, no done pulse; a subsequent start runs normally.
